// File: rtl/perceptron_pkg.sv
// Shared types, constants and helpers for the perceptron trainer.
package perceptron_pkg;

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      EVAL,
      UPDATE,
      EPOCH_END,
      DONE
   } state_t;

   typedef logic signed [1:0] err_t;

   localparam int LIMIAR = 1;

   // Signed add clamped to the range of a width-bit two's-complement value (width <= 32).
   function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                  input logic signed [31:0] b,
                                                  input int unsigned        width);
      logic signed [32:0] sum;
      logic signed [32:0] hi;
      logic signed [32:0] lo;
      sum = 33'(a) + 33'(b);
      hi  = (33'sd1 <<< (width - 1)) - 33'sd1;
      lo  = -(33'sd1 <<< (width - 1));
      if (sum > hi) begin
         return 32'(hi);
      end
      if (sum < lo) begin
         return 32'(lo);
      end
      return 32'(sum);
   endfunction

endpackage

// File: rtl/perceptron_trainer_if.sv
// Host-side bus of the perceptron trainer: control, table writes and trained results.
interface perceptron_trainer_if #(
   parameter int unsigned N_IN   = 2,
   parameter int unsigned W_W    = 8,
   parameter int unsigned N_SAMP = 4,
   parameter int unsigned EP_W   = 4
);
   localparam int unsigned AW = $clog2(N_SAMP);

   logic                   start;
   logic [EP_W-1:0]        epocas;
   logic                   wr_en;
   logic [AW-1:0]          wr_addr;
   logic [N_IN-1:0]        wr_x;
   logic                   wr_y;
   logic                   busy;
   logic                   done;
   logic                   converged;
   logic [N_IN*W_W-1:0]    w;
   logic [W_W-1:0]         bias;
   logic [EP_W-1:0]        ep_count;

   modport master (
      output start, epocas, wr_en, wr_addr, wr_x, wr_y,
      input  busy, done, converged, w, bias, ep_count
   );

   modport slave (
      input  start, epocas, wr_en, wr_addr, wr_x, wr_y,
      output busy, done, converged, w, bias, ep_count
   );
endinterface

// File: rtl/perceptron_neuron.sv
// Combinational neuron: weighted sum, thresholded prediction and signed error.
// Bias input and s+bias>=0 decision rule exist only with PERCEPTRON_BIAS_EN.
module perceptron_neuron
   import perceptron_pkg::*;
#(
   parameter int unsigned N_IN = 2,
   parameter int unsigned W_W  = 8
) (
   input  logic [N_IN-1:0]        x,
   input  logic                   y,
   input  logic [N_IN*W_W-1:0]    w,
`ifdef PERCEPTRON_BIAS_EN
   input  logic signed [W_W-1:0]  bias,
`endif
   output logic                   pred_c,
   output err_t                   err_c
);
   localparam int unsigned SW = W_W + $clog2(N_IN + 1);

   logic signed [SW-1:0] s_c;
`ifdef PERCEPTRON_BIAS_EN
   logic signed [SW:0]   sb_c;
`endif

   // Sum is wide enough that N_IN full-scale weights cannot overflow it.
   always_comb begin
      s_c = '0;
      for (int i = 0; i < int'(N_IN); i++) begin
         if (x[i]) begin
            s_c = s_c + SW'(signed'(w[i*W_W +: W_W]));
         end
      end
   end

   always_comb begin
`ifdef PERCEPTRON_BIAS_EN
      sb_c   = (SW+1)'(s_c) + (SW+1)'(bias);
      pred_c = ~sb_c[SW];
`else
      pred_c = (s_c >= SW'(LIMIAR));
`endif
      err_c  = err_t'({1'b0, y}) - err_t'({1'b0, pred_c});
   end

endmodule

// File: rtl/perceptron_trainer.sv
// Perceptron trainer: sample table, control FSM, saturating weights, early stop.
// Optional trainable bias when PERCEPTRON_BIAS_EN is defined.
module perceptron_trainer
   import perceptron_pkg::*;
#(
   parameter int unsigned N_IN   = 2,
   parameter int unsigned W_W    = 8,
   parameter int unsigned N_SAMP = 4,
   parameter int unsigned EP_W   = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   perceptron_trainer_if.slave  bus
);
   localparam int unsigned AW = $clog2(N_SAMP);

   state_t               state_q, state_d;
   logic [N_IN-1:0]      x_tab [N_SAMP];
   logic                 y_tab [N_SAMP];
   logic [AW-1:0]        n_q;
   logic [EP_W-1:0]      ep_q;
   logic [EP_W-1:0]      ep_next_c;
   logic [EP_W-1:0]      epocas_q;
   logic [N_IN*W_W-1:0]  w_q;
   logic signed [W_W-1:0] bias_q;
   err_t                 err_q;
   err_t                 err_c;
   logic                 pred_c;
   logic                 err_flag_q;
   logic                 busy_q, done_q, conv_q;
   logic                 last_c;

   assign ep_next_c = ep_q + EP_W'(1);
   assign last_c    = (n_q == AW'(N_SAMP - 1));

   perceptron_neuron #(.N_IN(N_IN), .W_W(W_W)) u_neuron (
      .x      (x_tab[n_q]),
      .y      (y_tab[n_q]),
      .w      (w_q),
`ifdef PERCEPTRON_BIAS_EN
      .bias   (bias_q),
`endif
      .pred_c (pred_c),
      .err_c  (err_c)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:      if (bus.start) state_d = CLEAR;
         CLEAR:     state_d = (epocas_q == '0) ? DONE : EVAL;
         EVAL:      state_d = UPDATE;
         UPDATE:    state_d = last_c ? EPOCH_END : EVAL;
         EPOCH_END: state_d = (!err_flag_q || ep_next_c == epocas_q) ? DONE : EVAL;
         DONE:      state_d = IDLE;
         default:   state_d = IDLE;
      endcase
   end

   // Datapath, table and registered status outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < int'(N_SAMP); k++) begin
            x_tab[k] <= '0;
            y_tab[k] <= 1'b0;
         end
         n_q        <= '0;
         ep_q       <= '0;
         epocas_q   <= '0;
         w_q        <= '0;
         bias_q     <= '0;
         err_q      <= '0;
         err_flag_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         conv_q     <= 1'b0;
      end else begin
         if (bus.wr_en && !busy_q) begin
            x_tab[bus.wr_addr] <= bus.wr_x;
            y_tab[bus.wr_addr] <= bus.wr_y;
         end
         busy_q <= (state_d != IDLE);
         done_q <= (state_d == DONE);
         case (state_q)
            IDLE: if (bus.start) epocas_q <= bus.epocas;
            CLEAR: begin
               w_q        <= '0;
               bias_q     <= '0;
               n_q        <= '0;
               ep_q       <= '0;
               conv_q     <= 1'b0;
               err_flag_q <= 1'b0;
            end
            EVAL: err_q <= err_c;
            UPDATE: begin
               if (err_q != '0) begin
                  for (int i = 0; i < int'(N_IN); i++) begin
                     if (x_tab[n_q][i]) begin
                        w_q[i*W_W +: W_W] <= W_W'(sat_add(32'(signed'(w_q[i*W_W +: W_W])),
                                                          32'(err_q), W_W));
                     end
                  end
`ifdef PERCEPTRON_BIAS_EN
                  bias_q <= W_W'(sat_add(32'(bias_q), 32'(err_q), W_W));
`endif
                  err_flag_q <= 1'b1;
               end
               if (!last_c) n_q <= n_q + AW'(1);
            end
            EPOCH_END: begin
               ep_q <= ep_next_c;
               if (!err_flag_q) begin
                  conv_q <= 1'b1;
               end else if (ep_next_c != epocas_q) begin
                  err_flag_q <= 1'b0;
                  n_q        <= '0;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.converged = conv_q;
   assign bus.w         = w_q;
   assign bus.ep_count  = ep_q;
`ifdef PERCEPTRON_BIAS_EN
   assign bus.bias      = bias_q;
`else
   assign bus.bias      = '0;
`endif

endmodule

// File: tb/tb_perceptron_trainer.sv
// Bench for perceptron_trainer: per-cycle trace model of the training algorithm plus fixed scenarios.
module tb_perceptron_trainer;
   import perceptron_pkg::*;

   localparam int unsigned N_IN   = 2;
   localparam int unsigned W_W    = 8;
   localparam int unsigned N_SAMP = 4;
   localparam int unsigned EP_W   = 4;
   localparam int unsigned AW     = $clog2(N_SAMP);

   typedef struct packed {
      int                  cyc;
      logic                busy;
      logic                done;
      logic                conv;
      logic [EP_W-1:0]     ep;
      logic [N_IN*W_W-1:0] w;
      logic [W_W-1:0]      b;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   perceptron_trainer_if #(.N_IN(N_IN), .W_W(W_W), .N_SAMP(N_SAMP), .EP_W(EP_W)) bus ();
   perceptron_trainer #(.N_IN(N_IN), .W_W(W_W), .N_SAMP(N_SAMP), .EP_W(EP_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   int run_c0 = 0;
   int last_done = -1;
   int done_cnt = 0;
   exp_t exp_q[$];
   exp_t e_cur;

   // Reference state: the training table and the algorithm's registers as plain integers.
   int mw [N_IN];
   int mb;
   int mep;
   bit mconv;
   bit [N_IN-1:0] tx [N_SAMP];
   bit ty [N_SAMP];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int req);
      tests++;
      if (act != req) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask

   function automatic int sat_m(input int v);
      int hi = (1 << (W_W - 1)) - 1;
      int lo = -(1 << (W_W - 1));
      return (v > hi) ? hi : (v < lo) ? lo : v;
   endfunction

   function automatic logic [N_IN*W_W-1:0] pack_w();
      logic [N_IN*W_W-1:0] r;
      for (int i = 0; i < int'(N_IN); i++) r[i*W_W +: W_W] = W_W'(mw[i]);
      return r;
   endfunction

   task automatic push(input int c, input bit busy, input bit done);
      exp_t e;
      e.cyc = c; e.busy = busy; e.done = done; e.conv = mconv;
      e.ep = EP_W'(mep); e.w = pack_w(); e.b = W_W'(mb);
      exp_q.push_back(e);
   endtask

   // Expected outputs for each cycle of a run started at cycle c0 (start is cycle 0).
   task automatic model_run(input int c0, input int ep_lim);
      int c = c0 + 1;
      bit errs;
      int s, pred, err;
      push(c, 1, 0); c++;
      for (int i = 0; i < int'(N_IN); i++) mw[i] = 0;
      mb = 0; mep = 0; mconv = 0;
      if (ep_lim != 0) begin
         for (int e = 0; e < ep_lim; e++) begin
            errs = 0;
            for (int n = 0; n < int'(N_SAMP); n++) begin
               push(c, 1, 0); c++;
               push(c, 1, 0); c++;
               s = 0;
               for (int i = 0; i < int'(N_IN); i++) if (tx[n][i]) s += mw[i];
`ifdef PERCEPTRON_BIAS_EN
               pred = (s + mb >= 0) ? 1 : 0;
`else
               pred = (s >= 1) ? 1 : 0;
`endif
               err = int'(ty[n]) - pred;
               if (err != 0) begin
                  errs = 1;
                  for (int i = 0; i < int'(N_IN); i++) if (tx[n][i]) mw[i] = sat_m(mw[i] + err);
`ifdef PERCEPTRON_BIAS_EN
                  mb = sat_m(mb + err);
`endif
               end
            end
            push(c, 1, 0); c++;
            mep++;
            if (!errs) begin
               mconv = 1;
               break;
            end
         end
      end
      push(c, 1, 1); c++;
      push(c, 0, 0);
   endtask

   // One compare per modelled cycle, sampled on the falling edge.
   always @(negedge clk) begin
      if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
         e_cur = exp_q.pop_front();
         tests++;
         if (e_cur.cyc != cyc || bus.busy !== e_cur.busy || bus.done !== e_cur.done ||
             bus.converged !== e_cur.conv || bus.ep_count !== e_cur.ep ||
             bus.w !== e_cur.w || bus.bias !== e_cur.b) begin
            fails++;
            $display("FAIL trace cyc %0d: got busy=%b done=%b conv=%b ep=%0d w=%h bias=%h, expected cyc %0d busy=%b done=%b conv=%b ep=%0d w=%h bias=%h",
                     cyc, bus.busy, bus.done, bus.converged, bus.ep_count, bus.w, bus.bias,
                     e_cur.cyc, e_cur.busy, e_cur.done, e_cur.conv, e_cur.ep, e_cur.w, e_cur.b);
         end
      end
      if (bus.done === 1'b1) begin
         done_cnt++;
         last_done = cyc;
      end
   end

   task automatic wr(input int a, input bit [N_IN-1:0] x, input bit y);
      @(negedge clk);
      bus.wr_en = 1'b1; bus.wr_addr = AW'(a); bus.wr_x = x; bus.wr_y = y;
      @(negedge clk);
      bus.wr_en = 1'b0;
      tx[a] = x; ty[a] = y;
   endtask

   task automatic load(input bit [N_SAMP-1:0] ys);
      for (int a = 0; a < int'(N_SAMP); a++) wr(a, N_IN'(a), ys[a]);
   endtask

   task automatic start_run(input int ep);
      @(negedge clk);
      run_c0 = cyc;
      last_done = -1;
      bus.start = 1'b1; bus.epocas = EP_W'(ep);
      model_run(run_c0, ep);
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   task automatic wait_run(output int rel);
      int k = 0;
      while (exp_q.size() > 0 && k < 600) begin
         @(posedge clk);
         k++;
      end
      if (exp_q.size() > 0) begin
         tests++; fails++;
         $display("FAIL run timeout: %0d expected cycles left, expected 0", exp_q.size());
         exp_q.delete();
      end
      rel = (last_done < 0) ? -1 : last_done - run_c0;
   endtask

   task automatic run(input int ep, output int rel);
      start_run(ep);
      wait_run(rel);
   endtask

   function automatic int wsig(input int i);
      logic [N_IN*W_W-1:0] wv = bus.w;
      return int'($signed(wv[i*W_W +: W_W]));
   endfunction

   task automatic check_or(input string tag, input int rel);
`ifdef PERCEPTRON_BIAS_EN
      check({tag, " conv"}, int'(bus.converged), 1);
      check({tag, " ep"}, int'(bus.ep_count), 4);
      check({tag, " w0"}, wsig(0), 1);
      check({tag, " w1"}, wsig(1), 1);
      check({tag, " bias"}, int'($signed(bus.bias)), -1);
      check({tag, " done cyc"}, rel, 38);
`else
      check({tag, " conv"}, int'(bus.converged), 1);
      check({tag, " ep"}, int'(bus.ep_count), 2);
      check({tag, " w0"}, wsig(0), 1);
      check({tag, " w1"}, wsig(1), 1);
      check({tag, " done cyc"}, rel, 20);
`endif
   endtask

   initial begin
      int rel;
      int ep;
      int dc;
      bus.start = 1'b0; bus.epocas = '0; bus.wr_en = 1'b0;
      bus.wr_addr = '0; bus.wr_x = '0; bus.wr_y = 1'b0;
      for (int i = 0; i < int'(N_IN); i++) mw[i] = 0;
      mb = 0; mep = 0; mconv = 0;
      for (int a = 0; a < int'(N_SAMP); a++) begin tx[a] = '0; ty[a] = 0; end
      repeat (3) @(negedge clk);
      check("reset busy", int'(bus.busy), 0);
      check("reset done", int'(bus.done), 0);
      check("reset conv", int'(bus.converged), 0);
      check("reset w", int'(bus.w), 0);
      check("reset ep", int'(bus.ep_count), 0);
      check("reset bias", int'(bus.bias), 0);
      rst_n = 1'b1;

      check("sat hi", int'(sat_add(32'sd127, 32'sd1, W_W)), 127);
      check("sat lo", int'(sat_add(-32'sd128, -32'sd1, W_W)), -128);
      check("sat mid", int'(sat_add(32'sd5, -32'sd1, W_W)), 4);
      check("sat w4", int'(sat_add(32'sd6, 32'sd3, 4)), 7);

      // OR training.
      load(4'b1110);
      run(4, rel);
      check_or("or", rel);
`ifdef PERCEPTRON_BIAS_EN
      run(6, rel);
      check_or("or6", rel);
`endif

      // AND training, epoch limit reached.
      load(4'b1000);
      run(3, rel);
`ifndef PERCEPTRON_BIAS_EN
      check("and conv", int'(bus.converged), 0);
      check("and ep", int'(bus.ep_count), 3);
      check("and w0", wsig(0), 1);
      check("and w1", wsig(1), 1);
`endif

      // Zero epoch limit.
      run(0, rel);
      check("ep0 done cyc", rel, 2);
      check("ep0 conv", int'(bus.converged), 0);
      check("ep0 w", int'(bus.w), 0);
      check("ep0 ep", int'(bus.ep_count), 0);

      // Table write and restart while busy are ignored.
      load(4'b1110);
      start_run(4);
      repeat (3) @(negedge clk);
      bus.wr_en = 1'b1; bus.wr_addr = AW'(1); bus.wr_x = N_IN'(1); bus.wr_y = 1'b0;
      @(negedge clk);
      bus.wr_en = 1'b0; bus.start = 1'b1; bus.epocas = EP_W'(1);
      @(negedge clk);
      bus.start = 1'b0;
      wait_run(rel);
      check_or("busy wr", rel);
      run(4, rel);
      check_or("after wr", rel);

      // Reset in the middle of epoch 1.
      start_run(4);
      repeat (4) @(negedge clk);
      #2;
      rst_n = 1'b0;
      exp_q.delete();
      dc = done_cnt;
      #1;
      check("midrst busy", int'(bus.busy), 0);
      check("midrst w", int'(bus.w), 0);
      check("midrst ep", int'(bus.ep_count), 0);
      check("midrst conv", int'(bus.converged), 0);
      repeat (3) @(negedge clk);
      check("midrst no done", done_cnt, dc);
      #2;
      rst_n = 1'b1;
      for (int i = 0; i < int'(N_IN); i++) mw[i] = 0;
      mb = 0; mep = 0; mconv = 0;
      for (int a = 0; a < int'(N_SAMP); a++) begin tx[a] = '0; ty[a] = 0; end
      load(4'b1110);
      run(4, rel);
      check_or("rerun", rel);

      // Random tables and epoch limits against the model.
      for (int it = 0; it < 25; it++) begin
         if ($urandom_range(0, 2) != 0) begin
            for (int a = 0; a < int'(N_SAMP); a++)
               wr(a, N_IN'($urandom_range(0, (1 << N_IN) - 1)), 1'($urandom_range(0, 1)));
         end
         ep = $urandom_range(0, 9);
         run(ep, rel);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/perceptron_trainer.md
# perceptron_trainer

Parametrised single-layer perceptron trainer with an integrated control FSM, a writable training table, saturating signed weights and early stop on a zero-error epoch. It is the next generation of the two-input OR perceptron datapath: input count, weight width, table depth and epoch limit are generic. It sits between the host/stimulus logic, which loads samples and issues `start`, and any consumer of the trained weights.

## Interface
- `N_IN`, 2: number of binary inputs (1..8).
- `W_W`, 8: signed weight/bias width.
- `N_SAMP`, 4: training table depth (2..16).
- `EP_W`, 4: epoch counter width.
- `clk`  in  1: clock, rising edge.
- `rst_n`  in  1: asynchronous active-low reset.
- `start`  in  1: one-cycle pulse, accepted only in IDLE.
- `epocas`  in  EP_W: epoch limit, sampled on accepted `start`.
- `wr_en`  in  1: table write strobe, honoured only when `busy`=0.
- `wr_addr`  in  clog2(N_SAMP): table write index.
- `wr_x`  in  N_IN: sample inputs; bit i drives weight i.
- `wr_y`  in  1: sample target.
- `busy`  out  1: high from the accepted `start` until DONE is left.
- `done`  out  1: one-cycle pulse in DONE.
- `converged`  out  1: last run ended on an error-free epoch. Held until the next `start`.
- `w`  out  N_IN*W_W: weights; weight i is in `w[i*W_W +: W_W]`. Signed.
- `bias`  out  W_W: bias weight. Signed.
- `ep_count`  out  EP_W: epochs completed in the current or last run.

## Operation
- Reset: FSM in IDLE. `w`, `bias`, `ep_count`, `busy`, `done`, `converged` are all 0. Table contents are cleared to 0.
- FSM states are IDLE, CLEAR, EVAL, UPDATE, EPOCH_END, DONE.
- IDLE + `start`: go to CLEAR and latch `epocas`.
- CLEAR: zero the weights, `bias`, sample index n, `ep_count`, `converged` and the epoch error flag. If `epocas`=0, go to DONE with `converged`=0. Otherwise go to EVAL.
- EVAL, combinational sum: s = Σ w_i·x_i over bits of x[n]. The sum is signed and W_W+clog2(N_IN+1) bits wide, so it cannot overflow.
- EVAL, prediction and error: pred = (s ≥ 1), or (s+bias ≥ 0) with bias enabled. Register err = y[n] − pred as a 2-bit signed value in {−1,0,+1}.
- UPDATE, weights: if err≠0, set w_i ← sat(w_i + err·x_i[n]) and set the epoch error flag. With bias enabled, also set bias ← sat(bias + err).
- Saturation clamps to [−2^(W_W−1), 2^(W_W−1)−1].
- UPDATE, next state: if n=N_SAMP−1, go to EPOCH_END. Otherwise n←n+1 and go to EVAL.
- EPOCH_END always does ep_count←ep_count+1. Then:
  - error flag clear: set `converged`=1 and go to DONE;
  - else if the new ep_count equals `epocas`: go to DONE;
  - else clear the flag, set n←0 and go to EVAL.
- DONE: `done`=1 for exactly one cycle, then IDLE. Weights are held.
- `start` while `busy` is ignored. `wr_en` while `busy` is ignored; the table is unchanged.
- `rst_n` low mid-run: immediate return to reset values, with no `done` pulse.

## Timing
- A table write takes effect on the `clk` edge where `wr_en`=1. The written sample is readable by a run started on the next cycle.
- Run timing, counting `start` as cycle 0:
  - CLEAR occupies cycle 1.
  - Each sample takes 2 cycles (EVAL, UPDATE).
  - Each epoch takes 2·N_SAMP+1 cycles.
  - `done` asserts 1 cycle after the final EPOCH_END.
  - `busy` falls together with `done`'s deassertion.
- With `epocas`=0: `done` on cycle 2 and `ep_count`=0.
- Weights update on the UPDATE edge and are visible on `w` the next cycle.
- `converged` and `ep_count` are valid while `done`=1 and stay stable afterwards.

## Configuration
- `PERCEPTRON_BIAS_EN`, defined: a trainable bias register is instantiated. The decision rule is s+bias ≥ 0, and bias is updated like a weight whose input is fixed at 1.
- `PERCEPTRON_BIAS_EN`, undefined: there is no bias register. The fixed threshold is 1, and `bias` is tied to 0.

## Structure
- Package `perceptron_pkg` holds:
  - the FSM state enum;
  - the error type (2-bit signed);
  - the threshold constant LIMIAR=1;
  - a saturating-add function parametrised by width.
- Sub-module `perceptron_neuron` is combinational. It takes x, the weights and the bias, and produces s, pred and err.
- The FSM, table, counters and weight registers live in `perceptron_trainer`.

## Test plan
- OR table {00→0, 01→1, 10→1, 11→1}, N_IN=2, bias off, `epocas`=4. Required: `done` with `converged`=1, `ep_count`=2, w0=1, w1=1, and `done` on cycle 20.
- AND table {00→0, 01→0, 10→0, 11→1}, bias off, `epocas`=3. Required: `converged`=0, `ep_count`=3, w0=1, w1=1.
- OR table, `PERCEPTRON_BIAS_EN` defined, `epocas`=6. Required: `converged`=1, `ep_count`=4, w0=1, w1=1, bias=−1.
- `epocas`=0. Required: `done` on cycle 2, `converged`=0, all weights 0.
- `wr_en` to address 1 with `wr_y`=0 during a run. Required: the table is unchanged and the OR result is identical to scenario 1. A second `start` while `busy` produces no effect.
- `rst_n` low during epoch 1 of the OR run, then released and restarted. Required: reset values immediately, no `done` pulse, and the rerun matches scenario 1.
